// File: rtl/lsu_dmem_master.sv
// lsu_dmem_master: load/store initiator between the MEM stage and a
// word-indexed data memory. Checks alignment and range, steers byte lanes,
// extends load data, and turns sub-word stores into read-modify-write of a
// full word because the memory only writes whole words reliably.
`timescale 1ns/1ps
module lsu_dmem_master #(
   parameter int DEPTH = 2048,
   parameter int IDX_W = 11
) (
   input  logic        clk,
   input  logic        rst,
   // request from MEM stage
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   // response to MEM stage
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   // data memory port
   output logic        dmem_ena,
   output logic        dmem_wena,
   output logic [31:0] dmem_addr,
   output logic [1:0]  dmem_type,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata
);

   localparam logic [1:0]  SIZE_WORD = 2'b00;
   localparam logic [1:0]  SIZE_HALF = 2'b01;
   localparam logic [1:0]  SIZE_BYTE = 2'b10;
   localparam logic [1:0]  SIZE_ILL  = 2'b11;
   localparam logic [29:0] DEPTH_W   = 30'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_STORE,
      S_RMW_RD,
      S_RMW_WR,
      S_RESP
   } state_t;

   state_t state_q, state_d;

   // Latched request; only the address bits that select lane and word are kept.
   logic [1:0]       size_q;
   logic             uns_q;
   logic [IDX_W+1:0] addr_q;
   logic [31:0]      wdata_q;

   logic [31:0]      rdata_q;
   logic             err_q;
   logic [31:0]      merge_q;
   logic             req_err;

   // Pick the addressed byte or halfword out of a word and extend it to 32 bits.
   function automatic logic [31:0] load_extend(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic        uns,
                                               input logic [1:0]  lane);
      logic [31:0] shifted;
      logic [15:0] half;
      logic [31:0] res;
      shifted = word >> {lane, 3'b000};
      half    = lane[1] ? word[31:16] : word[15:0];
      case (size)
         SIZE_HALF: res = uns ? {16'h0000, half} : {{16{half[15]}}, half};
         SIZE_BYTE: res = uns ? {24'h000000, shifted[7:0]}
                              : {{24{shifted[7]}}, shifted[7:0]};
         default:   res = word;
      endcase
      return res;
   endfunction

   // Replace the addressed lane of the old word with the right-aligned store data.
   function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
      logic [31:0] res;
      res = word;
      if (size == SIZE_BYTE) begin
         res[{lane, 3'b000} +: 8] = wdata[7:0];
      end else if (lane[1]) begin
         res[31:16] = wdata[15:0];
      end else begin
         res[15:0] = wdata[15:0];
      end
      return res;
   endfunction

   // Classify the incoming request: misaligned, illegal size or out of range.
   always_comb begin
      req_err = (req_size == SIZE_ILL)
             || ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00))
             || ((req_size == SIZE_HALF) && req_addr[0])
             || (req_addr[31:2] >= DEPTH_W);
   end

   // Next-state logic and memory-port drive, decoded from state and latched request.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
      state_d    = state_q;
      dmem_ena   = 1'b0;
      dmem_wena  = 1'b0;
      dmem_addr  = 32'h0;
      dmem_wdata = 32'h0;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               if (req_err)                    state_d = S_RESP;
               else if (!req_we)               state_d = S_LOAD;
               else if (req_size == SIZE_WORD) state_d = S_STORE;
               else                            state_d = S_RMW_RD;
            end
         end
         S_LOAD: begin
            dmem_ena  = 1'b1;
            dmem_addr = {{(32-IDX_W){1'b0}}, addr_q[IDX_W+1:2]};
            state_d   = S_RESP;
         end
         S_STORE: begin
            dmem_ena   = 1'b1;
            dmem_wena  = 1'b1;
            dmem_addr  = {{(32-IDX_W){1'b0}}, addr_q[IDX_W+1:2]};
            dmem_wdata = wdata_q;
            state_d    = S_RESP;
         end
         S_RMW_RD: begin
            dmem_ena  = 1'b1;
            dmem_addr = {{(32-IDX_W){1'b0}}, addr_q[IDX_W+1:2]};
            state_d   = S_RMW_WR;
         end
         S_RMW_WR: begin
            dmem_ena   = 1'b1;
            dmem_wena  = 1'b1;
            dmem_addr  = {{(32-IDX_W){1'b0}}, addr_q[IDX_W+1:2]};
            dmem_wdata = merge_q;
            state_d    = S_RESP;
         end
         S_RESP: begin
            if (resp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register, request latch, load capture and merge buffer.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst) begin
         state_q <= S_IDLE;
         size_q  <= SIZE_WORD;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
         merge_q <= 32'h0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  size_q  <= req_size;
                  uns_q   <= req_unsigned;
                  addr_q  <= req_addr[IDX_W+1:0];
                  wdata_q <= req_wdata;
                  rdata_q <= 32'h0;
                  err_q   <= req_err;
               end
            end
            S_LOAD: begin
               rdata_q <= load_extend(dmem_rdata, size_q, uns_q, addr_q[1:0]);
            end
            S_RMW_RD: begin
               merge_q <= merge_lane(dmem_rdata, wdata_q, size_q, addr_q[1:0]);
            end
            default: ;
         endcase
      end
   end

   assign req_ready  = (state_q == S_IDLE);
   assign resp_valid = (state_q == S_RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;
   assign dmem_type  = 2'b00;

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Testbench for lsu_dmem_master: directed scenarios followed by randomized
// transactions scored against a byte-level reference memory.
`timescale 1ns/1ps
module tb_lsu_dmem_master;

   localparam int DEPTH = 2048;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        dmem_ena;
   logic        dmem_wena;
   logic [31:0] dmem_addr;
   logic [1:0]  dmem_type;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;

   int checks = 0;
   int errors = 0;
   int ena_cnt = 0;
   int wr_cnt = 0;
   int type_bad = 0;

   logic [31:0] mem     [0:DEPTH-1];
   logic [31:0] ref_mem [0:DEPTH-1];

   lsu_dmem_master #(.DEPTH(DEPTH), .IDX_W(11)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .dmem_ena     (dmem_ena),
      .dmem_wena    (dmem_wena),
      .dmem_addr    (dmem_addr),
      .dmem_type    (dmem_type),
      .dmem_wdata   (dmem_wdata),
      .dmem_rdata   (dmem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Data memory: combinational read, write on the falling edge.
   assign dmem_rdata = (dmem_addr < DEPTH) ? mem[dmem_addr[10:0]] : 32'h0;
   always @(negedge clk) begin
      if (dmem_ena && dmem_wena) mem[dmem_addr[10:0]] <= dmem_wdata;
   end

   // Port activity counters used to check enable/write behaviour per request.
   always @(negedge clk) begin
      if (dmem_ena) ena_cnt <= ena_cnt + 1;
      if (dmem_ena && dmem_wena) wr_cnt <= wr_cnt + 1;
      if (dmem_ena && dmem_type != 2'b00) type_bad <= type_bad + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One full request/response exchange with immediate response handshake.
   task automatic txn(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err,
                      output int lat, output int enas, output int wrs);
      int e0, w0;
      @(posedge clk); #1;
      check("idle_ready", {31'b0, req_ready}, 32'd1);
      e0 = ena_cnt;
      w0 = wr_cnt;
      req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (resp_valid !== 1'b1 && lat < 16) begin
         @(posedge clk); #1;
         lat++;
      end
      rdata = resp_rdata;
      err   = resp_err;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      enas = ena_cnt - e0;
      wrs  = wr_cnt - w0;
   endtask

   // Reference: byte-addressed little-endian memory semantics in plain arithmetic.
   task automatic model(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic err,
                        output int lat, output int enas, output int wrs);
      int unsigned idx, off, nbytes;
      logic [31:0] mask, val, w;
      idx = addr / 4;
      off = addr % 4;
      nbytes = (size == 2'd0) ? 4 : (size == 2'd1) ? 2 : 1;
      err = (size == 2'd3) || (size == 2'd0 && off != 0) ||
            (size == 2'd1 && (off % 2) != 0) || (idx >= DEPTH);
      rd = 32'h0; lat = 1; enas = 0; wrs = 0;
      if (!err) begin
         mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
         w = ref_mem[idx];
         if (!we) begin
            val = (w >> (8 * off)) & mask;
            if (!uns && nbytes < 4 && val[8*nbytes-1]) val = val | ~mask;
            rd = val; lat = 2; enas = 1;
         end else begin
            ref_mem[idx] = (w & ~(mask << (8 * off))) | ((wdata & mask) << (8 * off));
            lat  = (nbytes == 4) ? 2 : 3;
            enas = (nbytes == 4) ? 1 : 2;
            wrs  = 1;
         end
      end
   endtask

   task automatic run_scored(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata);
      logic [31:0] rd, erd;
      logic        er, eer;
      int          lt, elt, en, een, wr, ewr;
      model(we, size, uns, addr, wdata, erd, eer, elt, een, ewr);
      txn(we, size, uns, addr, wdata, rd, er, lt, en, wr);
      check("rnd_rdata", rd, erd);
      check("rnd_err", {31'b0, er}, {31'b0, eer});
      check("rnd_latency", 32'(lt), 32'(elt));
      check("rnd_ena_cycles", 32'(en), 32'(een));
      check("rnd_writes", 32'(wr), 32'(ewr));
      if (!eer && we) check("rnd_mem_word", mem[addr[12:2]], ref_mem[addr[12:2]]);
   endtask

   logic [31:0] rd;
   logic        er;
   int          lt, en, wr;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic [31:0] addr;
   } err_case_t;

   err_case_t err_cases [4];

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
      req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_req_ready", {31'b0, req_ready}, 32'd1);
      check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'h0);
      check("rst_resp_err", {31'b0, resp_err}, 32'd0);
      check("rst_dmem_ena", {31'b0, dmem_ena}, 32'd0);
      check("rst_dmem_wena", {31'b0, dmem_wena}, 32'd0);
      check("rst_dmem_addr", dmem_addr, 32'h0);
      rst = 1'b0;

      // Word round trip
      txn(1'b1, 2'b00, 1'b0, 32'h10, 32'hDEAD_BEEF, rd, er, lt, en, wr);
      check("sw_latency", 32'(lt), 32'd2);
      check("sw_err", {31'b0, er}, 32'd0);
      check("sw_rdata", rd, 32'h0);
      check("sw_mem4", mem[4], 32'hDEAD_BEEF);
      txn(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, rd, er, lt, en, wr);
      check("lw_latency", 32'(lt), 32'd2);
      check("lw_rdata", rd, 32'hDEAD_BEEF);
      check("lw_err", {31'b0, er}, 32'd0);
      check("lw_writes", 32'(wr), 32'd0);

      // Byte read-modify-write and byte loads
      txn(1'b1, 2'b00, 1'b0, 32'h10, 32'h1122_3344, rd, er, lt, en, wr);
      txn(1'b1, 2'b10, 1'b0, 32'h12, 32'hFFFF_FFAB, rd, er, lt, en, wr);
      check("sb_latency", 32'(lt), 32'd3);
      check("sb_mem4", mem[4], 32'h11AB_3344);
      check("sb_writes", 32'(wr), 32'd1);
      txn(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, rd, er, lt, en, wr);
      check("lb_signed", rd, 32'hFFFF_FFAB);
      txn(1'b0, 2'b10, 1'b1, 32'h12, 32'h0, rd, er, lt, en, wr);
      check("lbu", rd, 32'h0000_00AB);

      // Halfword lanes
      txn(1'b1, 2'b00, 1'b0, 32'h14, 32'h8001_7FFE, rd, er, lt, en, wr);
      txn(1'b0, 2'b01, 1'b0, 32'h16, 32'h0, rd, er, lt, en, wr);
      check("lh_upper", rd, 32'hFFFF_8001);
      txn(1'b0, 2'b01, 1'b0, 32'h14, 32'h0, rd, er, lt, en, wr);
      check("lh_lower", rd, 32'h0000_7FFE);
      txn(1'b1, 2'b01, 1'b0, 32'h16, 32'hAAAA_1234, rd, er, lt, en, wr);
      check("sh_latency", 32'(lt), 32'd3);
      check("sh_mem5", mem[5], 32'h1234_7FFE);

      // Error requests never touch memory
      err_cases[0] = '{we: 1'b0, size: 2'b00, addr: 32'h0000_0002};
      err_cases[1] = '{we: 1'b1, size: 2'b01, addr: 32'h0000_0003};
      err_cases[2] = '{we: 1'b0, size: 2'b11, addr: 32'h0000_0000};
      err_cases[3] = '{we: 1'b0, size: 2'b00, addr: 32'h0000_2000};
      foreach (err_cases[i]) begin
         txn(err_cases[i].we, err_cases[i].size, 1'b0, err_cases[i].addr,
             32'h5555_5555, rd, er, lt, en, wr);
         check("err_flag", {31'b0, er}, 32'd1);
         check("err_rdata", rd, 32'h0);
         check("err_ena_cycles", 32'(en), 32'd0);
         check("err_latency", 32'(lt), 32'd1);
      end

      // Backpressure: response held, queued request waits for IDLE
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 32'h10;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lt = 1;
      while (resp_valid !== 1'b1 && lt < 16) begin
         @(posedge clk); #1;
         lt++;
      end
      check("bp_latency", 32'(lt), 32'd2);
      req_valid = 1'b1; req_size = 2'b10; req_unsigned = 1'b1; req_addr = 32'h13;
      for (int c = 0; c < 5; c++) begin
         check("bp_resp_valid", {31'b0, resp_valid}, 32'd1);
         check("bp_rdata", resp_rdata, 32'h11AB_3344);
         check("bp_err", {31'b0, resp_err}, 32'd0);
         check("bp_req_ready", {31'b0, req_ready}, 32'd0);
         @(posedge clk); #1;
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      check("bp_idle_ready", {31'b0, req_ready}, 32'd1);
      check("bp_idle_no_resp", {31'b0, resp_valid}, 32'd0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      lt = 1;
      while (resp_valid !== 1'b1 && lt < 16) begin
         @(posedge clk); #1;
         lt++;
      end
      check("bp_next_latency", 32'(lt), 32'd2);
      check("bp_next_rdata", resp_rdata, 32'h0000_0011);
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;

      // Reset while reading for a byte store aborts the write
      txn(1'b1, 2'b00, 1'b0, 32'h20, 32'hCAFE_F00D, rd, er, lt, en, wr);
      wr = wr_cnt;
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h20;
      req_wdata = 32'h0000_0055;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("rmw_rd_ena", {30'b0, dmem_ena, dmem_wena}, 32'd2);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rr_req_ready", {31'b0, req_ready}, 32'd1);
      check("rr_resp_valid", {31'b0, resp_valid}, 32'd0);
      check("rr_resp_rdata", resp_rdata, 32'h0);
      check("rr_resp_err", {31'b0, resp_err}, 32'd0);
      check("rr_dmem_ena", {30'b0, dmem_ena, dmem_wena}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check("rr_mem8", mem[8], 32'hCAFE_F00D);
      check("rr_no_write", 32'(wr_cnt - wr), 32'd0);

      // Randomized traffic: seed the words in use, then mixed requests
      for (int i = 0; i < 16; i++) run_scored(1'b1, 2'b00, 1'b0, 32'(i * 4), $urandom);
      for (int i = 2044; i < 2048; i++) run_scored(1'b1, 2'b00, 1'b0, 32'(i * 4), $urandom);
      for (int n = 0; n < 80; n++) begin
         logic [31:0] a;
         int unsigned idx;
         idx = ($urandom_range(0, 3) == 0) ? 2044 + $urandom_range(0, 7) : $urandom_range(0, 15);
         a = 32'(idx * 4 + $urandom_range(0, 3));
         if ($urandom_range(0, 15) == 0) a = a | 32'h8000_0000;
         run_scored(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), a, $urandom);
      end

      check("dmem_type_zero", 32'(type_bad), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/lsu_dmem_master.md
Name: lsu_dmem_master

Overview:
- CPU-side load/store initiator that drives the word-indexed data memory port (ena, wena, addr, dmem_type, data_in, data_out).
- Accepts byte-addressed load/store requests from the MEM stage over a valid/ready handshake.
- Performs alignment and range checks, selects the byte lane, and sign- or zero-extends load data.
- Implements byte and halfword stores as a read-modify-write of a full word, because the memory's sub-word write only updates the low bits of a word.

Parameters:
- DEPTH, 2048, number of 32-bit words in the data memory. Word index range is 0..DEPTH-1.
- IDX_W, 11, width of the word index (log2 DEPTH).

Ports:
- clk  input  1  system clock; FSM updates on posedge; the memory writes on negedge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted this cycle when req_valid & req_ready.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 word, 01 half, 10 byte, 11 illegal.
- req_unsigned  input  1  zero-extend loads when 1; sign-extend when 0.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; the relevant bits are right-aligned.
- resp_valid  output  1  response available.
- resp_ready  input  1  consumer takes the response.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  misaligned, out-of-range, or illegal size.
- dmem_ena  output  1  memory enable.
- dmem_wena  output  1  memory write enable.
- dmem_addr  output  32  word index = req_addr[31:2].
- dmem_type  output  2  always 00 (full-word write).
- dmem_wdata  output  32  full word to write.
- dmem_rdata  input  32  combinational read data from memory.

Behaviour:
- Byte lanes are little-endian. Lane = addr[1:0]; byte k occupies bits [8k+7:8k]; a halfword with addr[1]=1 occupies [31:16].
- Error conditions:
  - word access with addr[1:0] != 0;
  - half access with addr[0] = 1;
  - req_size = 11;
  - addr[31:2] >= DEPTH.
  - An erroring request never asserts dmem_ena.
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
- IDLE:
  - req_ready=1.
  - On handshake, latch all req_* fields and go to:
    - RESP with err=1, if any error condition holds;
    - LOAD, for a load;
    - STORE, for a word store;
    - RMW_RD, for a byte or half store.
- LOAD:
  - Drive dmem_ena=1, dmem_wena=0, dmem_addr=index.
  - At the posedge, capture the extracted and extended lane into resp_rdata, then go to RESP.
- STORE:
  - Drive dmem_ena=1, dmem_wena=1, dmem_wdata=latched wdata. The write occurs on the negedge inside this cycle.
  - Go to RESP.
- RMW_RD:
  - Drive dmem_ena=1, dmem_wena=0.
  - At the posedge, capture a merge buffer: dmem_rdata with the target lane replaced by wdata[7:0] (byte) or wdata[15:0] (half).
  - Go to RMW_WR.
- RMW_WR:
  - Drive dmem_ena=1, dmem_wena=1, dmem_wdata=merge buffer.
  - Go to RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_err stay stable while resp_ready=0.
  - On resp_ready, go to IDLE.
  - There is no bypass: a new request is accepted only in IDLE, one cycle after the response handshake.
- Latency, in posedges from the accept edge to resp_valid high:
  - load 2;
  - word store 2;
  - sub-word store 3;
  - error 1.
- In every state except LOAD, STORE, RMW_RD and RMW_WR: dmem_ena=0, dmem_wena=0, dmem_addr=0, dmem_wdata=0. dmem_type is always 00.
- Reset, when rst=1 at a posedge:
  - state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, merge buffer=0, dmem_ena=0, dmem_wena=0.
- Reset mid-operation:
  - A reset seen at a posedge while in STORE or RMW_WR still lets that cycle's negedge write complete. The memory is not protected.
  - A reset in RMW_RD aborts with no write.
- Outputs are registered state decodes. The dmem_* outputs may be combinational from the state register and the latched request, but never from the req_* inputs.

Test Plan:
- Word round-trip: store 0xDEADBEEF @0x10, then load word @0x10 -> dmem word[4] = 0xDEADBEEF; load resp_rdata = 0xDEADBEEF, err=0; latency 2 each.
- Byte RMW: word[4]=0x11223344, store byte 0xAB @0x12 -> word[4]=0x11AB3344. Then load byte signed @0x12 -> 0xFFFFFFAB; unsigned -> 0x000000AB.
- Half lanes: word[5]=0x8001_7FFE. Load half signed @0x16 -> 0xFFFF8001; load half signed @0x14 -> 0x00007FFE. Store half 0x1234 @0x16 -> word[5]=0x12347FFE.
- Errors, each giving resp_err=1, rdata=0, and dmem_ena never asserted:
  - word @0x02;
  - half @0x03;
  - size 11;
  - addr 0x2000 (index 2048).
- Backpressure: hold resp_ready=0 for 5 cycles after a load -> resp_valid and data stable, req_ready=0 throughout; a request presented then is accepted only after returning to IDLE.
- Reset in RMW_RD during byte store @0x20 (word[8]=0xCAFEF00D) -> word[8] unchanged, all outputs at reset values the next cycle.
